// File: rtl/bitfusion_pkg.sv
// Shared types, constants and helpers for the bitfusion job controller.
package bitfusion_pkg;

  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned PSUM_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Operand widths the fusion unit supports: 1, 2, 4 or 8 bits.
  function automatic logic width_legal(input logic [3:0] w);
    return (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
  endfunction

endpackage

// File: rtl/bitfusion_acc.sv
// Wide accumulator for fusion-unit partial sums, gated by the stage-valid flag.
module bitfusion_acc
  import bitfusion_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              stage_vld,
  input  logic              sext,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] psum_ext;

  // Extend the partial sum and compute the next accumulator value; clear wins.
  always_comb begin
    psum_ext = sext ? {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum}
                    : {{(ACC_W-PSUM_W){1'b0}}, psum};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (stage_vld) begin
      acc_d = acc_q + psum_ext;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/bitfusion_job_ctrl.sv
// Job sequencer: FSM, pair counter and registered operand stage for one fusion unit.
module bitfusion_job_ctrl
  import bitfusion_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [3:0]        in_width,
  input  logic [3:0]        weight_width,
  input  logic              s_in,
  input  logic              s_weight,
  output logic              busy,
  output logic              err,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [7:0]        op_in,
  input  logic [7:0]        op_weight,
  output logic [7:0]        fu_in,
  output logic [7:0]        fu_weight,
  output logic [3:0]        fu_in_width,
  output logic [3:0]        fu_weight_width,
  output logic              fu_s_in,
  output logic              fu_s_weight,
  input  logic [PSUM_W-1:0] fu_psum,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_acc
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       fu_in_q, fu_in_d;
  logic [7:0]       fu_weight_q, fu_weight_d;
  logic [3:0]       iw_q, iw_d;
  logic [3:0]       ww_q, ww_d;
  logic             si_q, si_d;
  logic             sw_q, sw_d;
  logic             stage_vld_q, stage_vld_d;
  logic             err_q, err_d;
  logic             acc_clr;
  logic             hs;
  logic [LEN_W-1:0] count_inc;

  assign hs        = (state_q == ST_RUN) && op_valid;
  assign count_inc = count_q + LEN_W'(1);

  // Next-state logic for the job FSM, counter, operand stage and config latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    fu_in_d     = fu_in_q;
    fu_weight_d = fu_weight_q;
    iw_d        = iw_q;
    ww_d        = ww_q;
    si_d        = si_q;
    sw_d        = sw_q;
    stage_vld_d = hs;
    err_d       = 1'b0;
    acc_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!(width_legal(in_width) && width_legal(weight_width))) begin
            err_d = 1'b1;
          end else if (len == '0) begin
            acc_clr = 1'b1;
            count_d = '0;
            state_d = ST_DONE;
          end else begin
            acc_clr = 1'b1;
            count_d = '0;
            len_d   = len;
            iw_d    = in_width;
            ww_d    = weight_width;
            si_d    = s_in;
            sw_d    = s_weight;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (hs) begin
          fu_in_d     = op_in;
          fu_weight_d = op_weight;
          count_d     = count_inc;
          if (count_inc == len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and operand-stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      len_q       <= '0;
      fu_in_q     <= '0;
      fu_weight_q <= '0;
      iw_q        <= '0;
      ww_q        <= '0;
      si_q        <= 1'b0;
      sw_q        <= 1'b0;
      stage_vld_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      fu_in_q     <= fu_in_d;
      fu_weight_q <= fu_weight_d;
      iw_q        <= iw_d;
      ww_q        <= ww_d;
      si_q        <= si_d;
      sw_q        <= sw_d;
      stage_vld_q <= stage_vld_d;
      err_q       <= err_d;
    end
  end

  bitfusion_acc #(
    .ACC_W(ACC_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (acc_clr),
    .stage_vld (stage_vld_q),
    .sext      (si_q | sw_q),
    .psum      (fu_psum),
    .acc       (res_acc)
  );

  assign busy            = (state_q != ST_IDLE);
  assign op_ready        = (state_q == ST_RUN);
  assign res_valid       = (state_q == ST_DONE);
  assign err             = err_q;
  assign fu_in           = fu_in_q;
  assign fu_weight       = fu_weight_q;
  assign fu_in_width     = iw_q;
  assign fu_weight_width = ww_q;
  assign fu_s_in         = si_q;
  assign fu_s_weight     = sw_q;

endmodule

// File: tb/tb_bitfusion_job_ctrl.sv
// Directed scoreboard bench for bitfusion_job_ctrl with a behavioural fusion unit.
module tb_bitfusion_job_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [3:0]  in_width = '0;
  logic [3:0]  weight_width = '0;
  logic        s_in = 1'b0;
  logic        s_weight = 1'b0;
  logic        busy, err, op_ready, res_valid;
  logic        op_valid = 1'b0;
  logic [7:0]  op_in = '0;
  logic [7:0]  op_weight = '0;
  logic [7:0]  fu_in, fu_weight;
  logic [3:0]  fu_in_width, fu_weight_width;
  logic        fu_s_in, fu_s_weight;
  logic [15:0] fu_psum;
  logic        res_ready = 1'b0;
  logic [31:0] res_acc;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  bitfusion_job_ctrl #(
    .LEN_W(8),
    .ACC_W(32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .len             (len),
    .in_width        (in_width),
    .weight_width    (weight_width),
    .s_in            (s_in),
    .s_weight        (s_weight),
    .busy            (busy),
    .err             (err),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_in           (op_in),
    .op_weight       (op_weight),
    .fu_in           (fu_in),
    .fu_weight       (fu_weight),
    .fu_in_width     (fu_in_width),
    .fu_weight_width (fu_weight_width),
    .fu_s_in         (fu_s_in),
    .fu_s_weight     (fu_s_weight),
    .fu_psum         (fu_psum),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_acc         (res_acc)
  );

  function automatic int opval(input logic [7:0] v, input logic [3:0] w, input logic s);
    int r;
    int m;
    if (w == 4'd0) return 0;
    m = (1 << w) - 1;
    r = int'(v) & m;
    if (s && (((r >> (w - 1)) & 1) != 0)) r = r - (1 << w);
    return r;
  endfunction

  // Behavioural fusion unit: width-masked, optionally signed product.
  always_comb begin
    fu_psum = 16'(opval(fu_in, fu_in_width, fu_s_in) * opval(fu_weight, fu_weight_width, fu_s_weight));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start_job(input logic [7:0] l, input logic [3:0] iw, input logic [3:0] ww,
                           input logic si, input logic sw);
    @(negedge clk);
    start = 1'b1; len = l; in_width = iw; weight_width = ww; s_in = si; s_weight = sw;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input string tag, input int n, input logic [7:0] a, input logic [7:0] b,
                      input bit gap, output int cyc);
    int got;
    got = 0;
    cyc = 0;
    op_in = a;
    op_weight = b;
    while (got < n && cyc < 64) begin
      op_valid = !(gap && (cyc % 2 == 1));
      if (op_valid && op_ready) got++;
      cyc++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk({tag, "_pairs"}, 32'(got), 32'(n));
  endtask

  task automatic finish_job(input string tag);
    logic [31:0] e;
    chk({tag, "_drain_rv"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_drain_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_done_rv"}, {31'd0, res_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_res_acc"}, res_acc, e);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_rv"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    int c;
    logic [31:0] e;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_acc", res_acc, 32'd0);
    chk("rst_fu_in", {24'd0, fu_in}, 32'd0);
    chk("rst_fu_iw", {28'd0, fu_in_width}, 32'd0);
    rst = 1'b0;

    // Unsigned 4-pair job, 3*5 each.
    start_job(8'd4, 4'd8, 4'd8, 1'b0, 1'b0);
    exp_q.push_back(32'd60);
    chk("u_busy", {31'd0, busy}, 32'd1);
    chk("u_op_ready", {31'd0, op_ready}, 32'd1);
    chk("u_fu_iw", {28'd0, fu_in_width}, 32'd8);
    feed("u", 4, 8'd3, 8'd5, 1'b0, c);
    chk("u_throughput", 32'(c), 32'd4);
    finish_job("u");

    // Signed 3-pair job, -2*3 each.
    start_job(8'd3, 4'd8, 4'd8, 1'b1, 1'b1);
    exp_q.push_back(32'hFFFF_FFEE);
    feed("s", 3, 8'hFE, 8'h03, 1'b0, c);
    finish_job("s");

    // Job with op_valid gaps, 4-bit widths, 2*9 each.
    start_job(8'd3, 4'd4, 4'd4, 1'b0, 1'b0);
    exp_q.push_back(32'd54);
    feed("g", 3, 8'd2, 8'd9, 1'b1, c);
    chk("g_cycles", 32'(c), 32'd5);
    finish_job("g");

    // Zero-length job goes straight to DONE with a cleared accumulator.
    start_job(8'd0, 4'd4, 4'd4, 1'b0, 1'b0);
    chk("z_rv", {31'd0, res_valid}, 32'd1);
    chk("z_res_acc", res_acc, 32'd0);
    chk("z_op_ready", {31'd0, op_ready}, 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("z_idle_busy", {31'd0, busy}, 32'd0);

    // Illegal width rejected with a single err pulse.
    start_job(8'd2, 4'd3, 4'd8, 1'b1, 1'b1);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("ill_err_pulse", {31'd0, err}, 32'd0);
    chk("ill_busy2", {31'd0, busy}, 32'd0);
    chk("ill_fu_iw", {28'd0, fu_in_width}, 32'd4);
    chk("ill_fu_ww", {28'd0, fu_weight_width}, 32'd4);
    chk("ill_fu_si", {31'd0, fu_s_in}, 32'd0);

    // Result backpressure with a start pulse that must be ignored.
    start_job(8'd2, 4'd8, 4'd8, 1'b0, 1'b0);
    exp_q.push_back(32'd84);
    feed("bp", 2, 8'd6, 8'd7, 1'b0, c);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        start = 1'b1; len = 8'd1; in_width = 4'd2; weight_width = 4'd2; s_in = 1'b1;
      end
      chk("bp_rv", {31'd0, res_valid}, 32'd1);
      chk("bp_res_acc", res_acc, 32'd84);
      @(negedge clk);
      start = 1'b0;
    end
    chk("bp_fu_iw", {28'd0, fu_in_width}, 32'd8);
    chk("bp_fu_si", {31'd0, fu_s_in}, 32'd0);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    if (exp_q.size() == 0) begin
      chk("bp_sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("bp_res_pop", res_acc, e);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("bp_start_dropped", {31'd0, busy}, 32'd0);

    // New job after the result handshake: s_in only, -1*2.
    start_job(8'd1, 4'd8, 4'd8, 1'b1, 1'b0);
    exp_q.push_back(32'hFFFF_FFFE);
    chk("n_busy", {31'd0, busy}, 32'd1);
    feed("n", 1, 8'hFF, 8'd2, 1'b0, c);
    finish_job("n");

    // Asynchronous reset in the middle of a run.
    start_job(8'd4, 4'd8, 4'd8, 1'b0, 1'b0);
    feed("r", 2, 8'd3, 8'd5, 1'b0, c);
    chk("r_pre_acc", res_acc, 32'd15);
    #2 rst = 1'b1;
    #1;
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_op_ready", {31'd0, op_ready}, 32'd0);
    chk("r_res_valid", {31'd0, res_valid}, 32'd0);
    chk("r_res_acc", res_acc, 32'd0);
    chk("r_fu_in", {24'd0, fu_in}, 32'd0);
    chk("r_fu_weight", {24'd0, fu_weight}, 32'd0);
    chk("r_fu_iw", {28'd0, fu_in_width}, 32'd0);
    chk("r_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_job(8'd1, 4'd8, 4'd8, 1'b0, 1'b0);
    exp_q.push_back(32'd14);
    feed("ra", 1, 8'd2, 8'd7, 1'b0, c);
    finish_job("ra");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
